// File: rtl/phase_accumulator.sv
// -----------------------------------------------------------------------------
// phase_accumulator
//
// Numerically controlled oscillator core. A tuning word is added into a phase
// register on every sample tick. Saw, variable-width square and triangle
// waveforms are derived from the top bits of the phase. Tuning words arrive
// over a ready/valid handshake into a one-entry pending slot. They are applied
// on the next tick, so the phase stays continuous across a retune.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   enable      sample tick; the phase advances only in cycles where it is high
//   tune_word   new phase increment (WIDTH bits)
//   tune_valid  tune_word offered
//   tune_ready  pending slot empty; a word transfers when valid && ready
//   sync        hard-sync request (one-cycle pulse)
//   wave_sel    00 saw, 01 square, 10 triangle, 11 mute
//   pw          square threshold (OUT_WIDTH bits)
//   wave_out    registered waveform sample (OUT_WIDTH bits, unsigned)
//   out_valid   one-cycle pulse; wave_out was updated
//   wrap        one-cycle pulse; the accumulator overflowed
// -----------------------------------------------------------------------------
module phase_accumulator #(
  parameter int WIDTH     = 24,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     tune_word,
  input  logic                 tune_valid,
  output logic                 tune_ready,
  input  logic                 sync,
  input  logic [1:0]           wave_sel,
  input  logic [OUT_WIDTH-1:0] pw,
  output logic [OUT_WIDTH-1:0] wave_out,
  output logic                 out_valid,
  output logic                 wrap
);

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_MUTE   = 2'b11
  } wave_e;

  logic [WIDTH-1:0]     phase;
  logic [WIDTH-1:0]     active_word;
  logic [WIDTH-1:0]     pend_word;
  logic                 pend_full;
  logic                 sync_pend;
  logic                 tick_d;      // a tick happened last cycle; sample its phase now

  logic                 accept;
  logic [WIDTH-1:0]     add_word;
  logic [WIDTH:0]       sum_full;    // MSB is the carry-out of the accumulator
  logic [OUT_WIDTH-1:0] wave_next;
  logic [OUT_WIDTH-1:0] saw_val;
  logic [OUT_WIDTH-1:0] tri_val;

  assign tune_ready = !pend_full;
  assign accept     = tune_valid && tune_ready;

  // A word waiting in the pending slot takes effect on the same tick that
  // promotes it, so the add must see it before active_word is updated.
  assign add_word = pend_full ? pend_word : active_word;
  assign sum_full = {1'b0, phase} + {1'b0, add_word};

  assign saw_val = phase[WIDTH-1 -: OUT_WIDTH];
  assign tri_val = phase[WIDTH-1] ? ~phase[WIDTH-2 -: OUT_WIDTH]
                                  :  phase[WIDTH-2 -: OUT_WIDTH];

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wave_next = '0;
    case (wave_e'(wave_sel))
      WAVE_SAW:    wave_next = saw_val;
      WAVE_SQUARE: wave_next = (saw_val < pw) ? '1 : '0;
      WAVE_TRI:    wave_next = tri_val;
      default:     wave_next = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase       <= '0;
      active_word <= '0;
      pend_word   <= '0;
      pend_full   <= 1'b0;
      sync_pend   <= 1'b0;
      wrap        <= 1'b0;
      tick_d      <= 1'b0;
    end else begin
      // Pending slot. A transfer requires the slot to be empty. A tick
      // empties it only when it is full, so the two never collide.
      if (accept) begin
        pend_word <= tune_word;
        pend_full <= 1'b1;
      end else if (enable && pend_full) begin
        pend_full <= 1'b0;
      end

      tick_d <= enable;

      if (enable) begin
        if (pend_full) begin
          active_word <= pend_word;
        end
        if (sync || sync_pend) begin
          phase     <= '0;
          wrap      <= 1'b0;
          sync_pend <= 1'b0;
        end else begin
          phase <= sum_full[WIDTH-1:0];
          wrap  <= sum_full[WIDTH];
        end
      end else begin
        wrap <= 1'b0;
        // A sync request that arrives between ticks is held for the next one.
        if (sync) begin
          sync_pend <= 1'b1;
        end
      end
    end
  end

  // Output stage: sample the phase one edge after the tick that moved it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wave_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= tick_d;
      if (tick_d) begin
        wave_out <= wave_next;
      end
    end
  end

endmodule
